// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline stage registers.
// Holds default widths, the bubble instruction and the IF/ID action selection.
package mips_pkg;

  localparam int unsigned NBITS_DEF     = 32;
  localparam int unsigned N_PC_DEF      = 2;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam int unsigned PC4_IDX = 0;
  localparam int unsigned PC8_IDX = 1;

  typedef enum logic [2:0] {
    ACT_FLUSH,
    ACT_DRAIN,
    ACT_LOAD,
    ACT_SKID,
    ACT_HOLD
  } stage_act_e;

  // Priority: flush, skid drain, main load, skid capture, hold.
  function automatic stage_act_e sel_act(input logic flush, input logic adv,
                                         input logic skid_valid, input logic xfer);
    if (flush)                 return ACT_FLUSH;
    else if (adv & skid_valid) return ACT_DRAIN;
    else if (adv)              return ACT_LOAD;
    else if (xfer)             return ACT_SKID;
    else                       return ACT_HOLD;
  endfunction

endpackage

// File: rtl/etapa_reg_entry.sv
// One {valid, PC bus, instruction} holding register, falling-edge clocked.
// Valid and data have separate write enables so a flush can clear valid alone.
module etapa_reg_entry #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned N_PC  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_we_valid,
  input  logic                    i_valid,
  input  logic                    i_we_data,
  input  logic [N_PC*NBITS-1:0]   i_PC,
  input  logic [NBITS-1:0]        i_Instruction,
  output logic                    o_valid,
  output logic [N_PC*NBITS-1:0]   o_PC,
  output logic [NBITS-1:0]        o_Instruction
);

  logic                  r_valid;
  logic [N_PC*NBITS-1:0] r_PC;
  logic [NBITS-1:0]      r_Instruction;

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid       <= 1'b0;
      r_PC          <= '0;
      r_Instruction <= '0;
    end else begin
      if (i_we_valid) r_valid <= i_valid;
      if (i_we_data) begin
        r_PC          <= i_PC;
        r_Instruction <= i_Instruction;
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_PC          = r_PC;
  assign o_Instruction = r_Instruction;

endmodule

// File: rtl/etapa_if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake, stall, flush and a
// one-entry skid buffer so fetch can finish one transfer into a stalled decode.
module etapa_if_id_skid
  import mips_pkg::*;
#(
  parameter int unsigned      NBITS     = NBITS_DEF,
  parameter int unsigned      N_PC      = N_PC_DEF,
  parameter logic [NBITS-1:0] NOP_INSTR = NBITS'(NOP_INSTR_DEF)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N_PC*NBITS-1:0] i_PC,
  input  logic [NBITS-1:0]      i_Instruction,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [N_PC*NBITS-1:0] o_PC,
  output logic [NBITS-1:0]      o_Instruction,
  output logic                  o_skid_full
);

  logic                  w_main_valid;
  logic [N_PC*NBITS-1:0] w_main_PC;
  logic [NBITS-1:0]      w_main_Instruction;
  logic                  w_skid_valid;
  logic [N_PC*NBITS-1:0] w_skid_PC;
  logic [NBITS-1:0]      w_skid_Instruction;

  logic       w_adv;
  logic       w_xfer;
  stage_act_e w_act;

  logic                  w_main_we_valid;
  logic                  w_main_valid_d;
  logic                  w_main_we_data;
  logic                  w_main_src_skid;
  logic [N_PC*NBITS-1:0] w_main_PC_d;
  logic [NBITS-1:0]      w_main_Instruction_d;
  logic                  w_skid_we_valid;
  logic                  w_skid_valid_d;
  logic                  w_skid_we_data;

  // Ready depends only on skid occupancy, so no combinational loop to fetch.
  assign o_ready = ~w_skid_valid;
  assign w_xfer  = i_valid & o_ready;
  assign w_adv   = ~w_main_valid | ~i_stall;
  assign w_act   = sel_act(i_flush, w_adv, w_skid_valid, w_xfer);

  always_comb begin
    w_main_we_valid = 1'b0;
    w_main_valid_d  = 1'b0;
    w_main_we_data  = 1'b0;
    w_main_src_skid = 1'b0;
    w_skid_we_valid = 1'b0;
    w_skid_valid_d  = 1'b0;
    w_skid_we_data  = 1'b0;
    case (w_act)
      ACT_FLUSH: begin
        w_main_we_valid = 1'b1;
        w_skid_we_valid = 1'b1;
      end
      ACT_DRAIN: begin
        w_main_we_valid = 1'b1;
        w_main_valid_d  = 1'b1;
        w_main_we_data  = 1'b1;
        w_main_src_skid = 1'b1;
        w_skid_we_valid = 1'b1;
      end
      ACT_LOAD: begin
        w_main_we_valid = 1'b1;
        w_main_valid_d  = w_xfer;
        w_main_we_data  = w_xfer;
      end
      ACT_SKID: begin
        w_skid_we_valid = 1'b1;
        w_skid_valid_d  = 1'b1;
        w_skid_we_data  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_main_PC_d          = w_main_src_skid ? w_skid_PC : i_PC;
  assign w_main_Instruction_d = w_main_src_skid ? w_skid_Instruction : i_Instruction;

  etapa_reg_entry #(
    .NBITS (NBITS),
    .N_PC  (N_PC)
  ) u_main (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_we_valid    (w_main_we_valid),
    .i_valid       (w_main_valid_d),
    .i_we_data     (w_main_we_data),
    .i_PC          (w_main_PC_d),
    .i_Instruction (w_main_Instruction_d),
    .o_valid       (w_main_valid),
    .o_PC          (w_main_PC),
    .o_Instruction (w_main_Instruction)
  );

  etapa_reg_entry #(
    .NBITS (NBITS),
    .N_PC  (N_PC)
  ) u_skid (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_we_valid    (w_skid_we_valid),
    .i_valid       (w_skid_valid_d),
    .i_we_data     (w_skid_we_data),
    .i_PC          (i_PC),
    .i_Instruction (i_Instruction),
    .o_valid       (w_skid_valid),
    .o_PC          (w_skid_PC),
    .o_Instruction (w_skid_Instruction)
  );

  assign o_valid       = w_main_valid;
  assign o_PC          = w_main_PC;
  assign o_Instruction = w_main_valid ? w_main_Instruction : NOP_INSTR;
  assign o_skid_full   = w_skid_valid;

endmodule

// File: tb/tb_etapa_if_id_skid.sv
// Bench for etapa_if_id_skid: directed vector table, async-reset and parameter
// sweep sequences, then random traffic checked against a queue model.
module tb_etapa_if_id_skid;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_stall, i_flush;
  logic [63:0] i_PC;
  logic [31:0] i_Instruction;
  logic        o_ready, o_valid, o_skid_full;
  logic [63:0] o_PC;
  logic [31:0] o_Instruction;

  logic        i2_valid;
  logic [47:0] i2_PC;
  logic [15:0] i2_Instruction;
  logic        o2_ready, o2_valid, o2_skid_full;
  logic [47:0] o2_PC;
  logic [15:0] o2_Instruction;

  always #5 clk = ~clk;

  etapa_if_id_skid #(.NBITS(32), .N_PC(2), .NOP_INSTR(32'h0000_0000)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_PC(i_PC), .i_Instruction(i_Instruction), .i_stall(i_stall),
    .i_flush(i_flush), .o_valid(o_valid), .o_PC(o_PC),
    .o_Instruction(o_Instruction), .o_skid_full(o_skid_full)
  );

  etapa_if_id_skid #(.NBITS(16), .N_PC(3), .NOP_INSTR(16'hFFFF)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_valid(i2_valid), .o_ready(o2_ready),
    .i_PC(i2_PC), .i_Instruction(i2_Instruction), .i_stall(1'b0),
    .i_flush(1'b0), .o_valid(o2_valid), .o_PC(o2_PC),
    .o_Instruction(o2_Instruction), .o_skid_full(o2_skid_full)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v, st, fl;
    logic [31:0] instr, pc;
    logic        ev, er, es;
    logic [31:0] ei, epc4;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  vec_t tbl[13];

  function automatic vec_t mk(input logic v, input logic st, input logic fl,
                              input logic [31:0] instr, input logic [31:0] pc,
                              input logic ev, input logic er, input logic es,
                              input logic [31:0] ei, input logic [31:0] epc4);
    vec_t t;
    t.v = v; t.st = st; t.fl = fl; t.instr = instr; t.pc = pc;
    t.ev = ev; t.er = er; t.es = es; t.ei = ei; t.epc4 = epc4;
    return t;
  endfunction

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [31:0] instr, input logic [31:0] pc);
    i_valid       = v;
    i_stall       = st;
    i_flush       = fl;
    i_Instruction = instr;
    i_PC          = '0;
    i_PC[PC4_IDX*32 +: 32] = pc + 32'd4;
    i_PC[PC8_IDX*32 +: 32] = pc + 32'd8;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'(q.size() > 0));
    chk({tag, ".ready"}, 64'(o_ready), 64'(q.size() < 2));
    chk({tag, ".skid"},  64'(o_skid_full), 64'(q.size() == 2));
    if (q.size() > 0) begin
      chk({tag, ".instr"}, 64'(o_Instruction), 64'(q[0].instr));
      chk({tag, ".pc4"},   64'(o_PC[PC4_IDX*32 +: 32]), 64'(q[0].pc + 32'd4));
      chk({tag, ".pc8"},   64'(o_PC[PC8_IDX*32 +: 32]), 64'(q[0].pc + 32'd8));
    end else begin
      chk({tag, ".nop"}, 64'(o_Instruction), 64'(32'h0));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'd0);
    chk({tag, ".instr"}, 64'(o_Instruction), 64'h0);
    chk({tag, ".pc"},    o_PC, 64'h0);
    chk({tag, ".ready"}, 64'(o_ready), 64'd1);
    chk({tag, ".skid"},  64'(o_skid_full), 64'd0);
  endtask

  initial begin
    logic        v, st, fl, rdy_pre;
    logic [31:0] ins, pc;
    ent_t        e;

    // A..H: A/B stream, C..H exercise stall, skid, flush and idle-stall.
    tbl[0]  = mk(1,0,0, 32'h2008_0005, 32'h00, 1,1,0, 32'h2008_0005, 32'h04);
    tbl[1]  = mk(1,0,0, 32'h2009_0003, 32'h04, 1,1,0, 32'h2009_0003, 32'h08);
    tbl[2]  = mk(0,0,0, 32'hDEAD_BEEF, 32'h08, 0,1,0, 32'h0000_0000, 32'h00);
    tbl[3]  = mk(1,0,0, 32'h012A_4020, 32'h0C, 1,1,0, 32'h012A_4020, 32'h10);
    tbl[4]  = mk(1,1,0, 32'h8C0B_0000, 32'h10, 1,0,1, 32'h012A_4020, 32'h10);
    tbl[5]  = mk(1,1,0, 32'hAC0C_0004, 32'h14, 1,0,1, 32'h012A_4020, 32'h10);
    tbl[6]  = mk(1,0,0, 32'hAC0C_0004, 32'h14, 1,1,0, 32'h8C0B_0000, 32'h14);
    tbl[7]  = mk(1,0,0, 32'hAC0C_0004, 32'h14, 1,1,0, 32'hAC0C_0004, 32'h18);
    tbl[8]  = mk(1,1,0, 32'h1000_FFFF, 32'h18, 1,0,1, 32'hAC0C_0004, 32'h18);
    tbl[9]  = mk(1,1,1, 32'h2400_0001, 32'h1C, 0,1,0, 32'h0000_0000, 32'h00);
    tbl[10] = mk(0,1,0, 32'h0000_1111, 32'h20, 0,1,0, 32'h0000_0000, 32'h00);
    tbl[11] = mk(1,1,0, 32'h3C01_1234, 32'h24, 1,1,0, 32'h3C01_1234, 32'h28);
    tbl[12] = mk(0,0,0, 32'h0000_0000, 32'h28, 0,1,0, 32'h0000_0000, 32'h00);

    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    i2_valid = 1'b0; i2_PC = '0; i2_Instruction = '0;
    #2;
    chk_reset_state("reset");
    chk("reset2.instr", 64'(o2_Instruction), 64'hFFFF);
    chk("reset2.valid", 64'(o2_valid), 64'd0);
    @(posedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].instr, tbl[i].pc);
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(o_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d.instr", i), 64'(o_Instruction), 64'(tbl[i].ei));
      chk($sformatf("vec%0d.ready", i), 64'(o_ready), 64'(tbl[i].er));
      chk($sformatf("vec%0d.skid", i),  64'(o_skid_full), 64'(tbl[i].es));
      if (tbl[i].ev)
        chk($sformatf("vec%0d.pc4", i), 64'(o_PC[PC4_IDX*32 +: 32]), 64'(tbl[i].epc4));
    end

    // Fill main and skid under stall, then reset between edges.
    drive(1, 0, 0, 32'h1111_0001, 32'h100); tick();
    drive(1, 1, 0, 32'h1111_0002, 32'h104); tick();
    chk("pre_rst.skid", 64'(o_skid_full), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    @(posedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0);

    // Parameter sweep instance: three independent PC words, 16'hFFFF bubble.
    i2_valid = 1'b1; i2_Instruction = 16'h1234; i2_PC = {16'h3333, 16'h2222, 16'h1111};
    tick();
    chk("p16.instr", 64'(o2_Instruction), 64'h1234);
    chk("p16.pc0", 64'(o2_PC[15:0]),  64'h1111);
    chk("p16.pc1", 64'(o2_PC[31:16]), 64'h2222);
    chk("p16.pc2", 64'(o2_PC[47:32]), 64'h3333);
    i2_valid = 1'b0;
    tick();
    chk("p16.bub_valid", 64'(o2_valid), 64'd0);
    chk("p16.bub_instr", 64'(o2_Instruction), 64'hFFFF);
    i2_valid = 1'b1; i2_Instruction = 16'h0BAD; i2_PC = {16'hC0C0, 16'h0BBB, 16'hAAAA};
    tick();
    chk("p16.pc0b", 64'(o2_PC[15:0]),  64'hAAAA);
    chk("p16.pc1b", 64'(o2_PC[31:16]), 64'h0BBB);
    chk("p16.pc2b", 64'(o2_PC[47:32]), 64'hC0C0);
    i2_valid = 1'b0;

    // Random traffic against an in-order queue model (depth two).
    q.delete();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int unsigned n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      ins = $urandom;
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      drive(v, st, fl, ins, pc);
      rdy_pre = (q.size() < 2);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && !st) void'(q.pop_front());
        if (v && rdy_pre) begin
          e.instr = ins;
          e.pc    = pc;
          q.push_back(e);
        end
      end
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
